ifb: RTL and testbench

//  Instruction fetch buffer between the PC/fetch stage and the IDU.
//  - Issues sequential instruction reads to instruction memory.
//  - Queues returned words with their PCs in a DEPTH-entry FIFO.
//  - Presents them to the IDU over a valid/ready handshake.
//  - On an EXU redirect: flushes the queue, discards in-flight responses and refetches from the target.

---
 rtl/ifb.sv | 135 +++++++++++++
 tb/tb_ifb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifb.sv
// Instruction fetch buffer: issues sequential fetches, queues returned words with
// their PCs, hands them to the IDU, and squashes everything on an EXU redirect.
module ifb #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RST_PC = 32'h8000_0000
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  output logic                      o_ifb_mem_req,
  output logic [ADDR_WIDTH-1:0]     o_ifb_mem_addr,
  input  logic                      i_mem_ack,
  input  logic                      i_mem_rvalid,
  input  logic [INST_WIDTH-1:0]     i_mem_rdata,
  input  logic                      i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0]     i_exu_jmp_pc,
  output logic                      o_ifb_valid,
  input  logic                      i_idu_ready,
  output logic [INST_WIDTH-1:0]     o_ifb_inst,
  output logic [ADDR_WIDTH-1:0]     o_ifb_pc,
  output logic [$clog2(DEPTH):0]    o_ifb_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INST_WIDTH + ADDR_WIDTH;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic [CW:0]           credit_sum;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] jmp_tgt;
  logic [EW-1:0]         head;
  logic                  unused_jmp_lsb;

  assign unused_jmp_lsb = ^i_exu_jmp_pc[1:0];
  assign jmp_tgt        = {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

  // Every accepted request owns a FIFO slot until its response is popped.
  assign credit_sum     = {1'b0, cnt_q} + {1'b0, outst_q};
  assign o_ifb_mem_req  = !i_sys_rst && (state_q == RUN) && !i_exu_jmp_en &&
                          (credit_sum < (CW+1)'(DEPTH));
  assign o_ifb_mem_addr = fetch_pc_q;
  assign accept         = o_ifb_mem_req && i_mem_ack;

  assign o_ifb_valid    = !i_sys_rst && (cnt_q != '0);
  assign head           = mem_q[rd_ptr_q];
  assign o_ifb_inst     = o_ifb_valid ? head[EW-1:ADDR_WIDTH] : '0;
  assign o_ifb_pc       = o_ifb_valid ? head[ADDR_WIDTH-1:0] : '0;
  assign o_ifb_cnt      = cnt_q;

  assign push = (state_q == RUN) && !i_exu_jmp_en && i_mem_rvalid;
  assign pop  = o_ifb_valid && i_idu_ready && !i_exu_jmp_en;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (i_exu_jmp_en) begin
      fetch_pc_d = jmp_tgt;
      resp_pc_d  = jmp_tgt;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      outst_d    = outst_q - CW'(i_mem_rvalid);
      // A re-redirect while flushing keeps the drop count, but a response
      // landing in that same cycle is still retired from it.
      if (state_q == RUN) drop_d = outst_q - CW'(i_mem_rvalid);
      else                drop_d = drop_q - CW'(i_mem_rvalid);
      state_d = (drop_d != '0) ? FLUSH : RUN;
    end else if (state_q == RUN) begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      outst_d = outst_q + CW'(accept) - CW'(i_mem_rvalid);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end else begin
      outst_d = outst_q - CW'(i_mem_rvalid);
      drop_d  = drop_q - CW'(i_mem_rvalid);
      if (drop_d == '0) state_d = RUN;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      cnt_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (push && !i_sys_rst) mem_q[wr_ptr_q] <= {i_mem_rdata, resp_pc_q};
  end

  // Responses must always match an outstanding request.
  rvalid_has_owner: assert property (@(posedge i_sys_clk) disable iff (i_sys_rst)
    i_mem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_ifb.sv
// Directed bench for ifb: a 1-cycle memory model with a hold switch lets
// responses be withheld so redirects can be exercised with requests in flight.
module tb_ifb;

  logic        i_sys_clk;
  logic        i_sys_rst;
  logic        o_ifb_mem_req;
  logic [31:0] o_ifb_mem_addr;
  logic        i_mem_ack;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_exu_jmp_en;
  logic [31:0] i_exu_jmp_pc;
  logic        o_ifb_valid;
  logic        i_idu_ready;
  logic [31:0] o_ifb_inst;
  logic [31:0] o_ifb_pc;
  logic [2:0]  o_ifb_cnt;

  int          n_cmp;
  int          n_bad;
  int          n_acc;
  bit          hold;
  logic [31:0] pend [$];

  ifb dut (
    .i_sys_clk      (i_sys_clk),
    .i_sys_rst      (i_sys_rst),
    .o_ifb_mem_req  (o_ifb_mem_req),
    .o_ifb_mem_addr (o_ifb_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata),
    .i_exu_jmp_en   (i_exu_jmp_en),
    .i_exu_jmp_pc   (i_exu_jmp_pc),
    .o_ifb_valid    (o_ifb_valid),
    .i_idu_ready    (i_idu_ready),
    .o_ifb_inst     (o_ifb_inst),
    .o_ifb_pc       (o_ifb_pc),
    .o_ifb_cnt      (o_ifb_cnt)
  );

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  // One clock cycle; memory answers each accepted request the following cycle
  // with data = ~addr, unless hold is set.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = o_ifb_mem_req && i_mem_ack && !i_sys_rst;
    a   = o_ifb_mem_addr;
    if (o_ifb_valid && i_idu_ready && !i_exu_jmp_en && !i_sys_rst)
      $display("pop  pc=%h inst=%h", o_ifb_pc, o_ifb_inst);
    if (acc) $display("req  addr=%h", a);
    @(posedge i_sys_clk);
    #1;
    if (acc) n_acc++;
    if (i_sys_rst) pend.delete();
    else if (acc) pend.push_back(a);
    if (!hold && pend.size() > 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = ~pend.pop_front();
    end else begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    i_sys_rst    = 1'b1;
    i_mem_ack    = 1'b0;
    i_idu_ready  = 1'b0;
    i_exu_jmp_en = 1'b0;
    i_exu_jmp_pc = '0;
    hold         = 1'b0;
    tick();
    tick();
    i_sys_rst = 1'b0;
    n_acc     = 0;
  endtask

  task automatic test_reset();
    i_sys_rst = 1'b1; i_mem_ack = 1'b1; i_idu_ready = 1'b1; i_exu_jmp_en = 1'b0;
    i_exu_jmp_pc = '0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; hold = 1'b0;
    tick();
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_ifb_valid); end
    n_cmp++; if (o_ifb_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", o_ifb_cnt); end
    n_cmp++; if (o_ifb_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", o_ifb_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    i_mem_ack = 1'b1; i_idu_ready = 1'b1;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req0: got %b want 1", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL stream_addr0: got %h want 80000000", o_ifb_mem_addr); end
    tick();
    n_cmp++; if (o_ifb_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid_c2: got %b want 0", o_ifb_valid); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL stream_addr1: got %h want 80000004", o_ifb_mem_addr); end
    tick();
    n_cmp++; if (o_ifb_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid_c3: got %b want 1", o_ifb_valid); end
    n_cmp++; if (o_ifb_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL stream_pc0: got %h want 80000000", o_ifb_pc); end
    n_cmp++; if (o_ifb_inst !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL stream_inst0: got %h want 7fffffff", o_ifb_inst); end
    n_cmp++; if (o_ifb_cnt !== 3'd1) begin n_bad++; $display("FAIL stream_cnt: got %0d want 1", o_ifb_cnt); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = 32'h8000_0000 + 32'(4 * k);
      n_cmp++; if (o_ifb_valid !== 1'b1 || o_ifb_pc !== e || o_ifb_inst !== ~e) begin
        n_bad++; $display("FAIL stream_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, o_ifb_valid, o_ifb_pc, o_ifb_inst, e, ~e);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_mem_ack = 1'b1; i_idu_ready = 1'b0;
    repeat (8) tick();
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL bp_accepts: got %0d want 4", n_acc); end
    n_cmp++; if (o_ifb_cnt !== 3'd4) begin n_bad++; $display("FAIL bp_cnt_full: got %0d want 4", o_ifb_cnt); end
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_full: got %b want 0", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL bp_head: got %h want 80000000", o_ifb_pc); end
    i_idu_ready = 1'b1;
    tick();
    i_idu_ready = 1'b0;
    #1;
    n_cmp++; if (o_ifb_cnt !== 3'd3) begin n_bad++; $display("FAIL bp_cnt_pop: got %0d want 3", o_ifb_cnt); end
    n_cmp++; if (o_ifb_mem_req !== 1'b1) begin n_bad++; $display("FAIL bp_req_resume: got %b want 1", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h8000_0010) begin n_bad++; $display("FAIL bp_addr_resume: got %h want 80000010", o_ifb_mem_addr); end
    n_cmp++; if (o_ifb_pc !== 32'h8000_0004) begin n_bad++; $display("FAIL bp_head2: got %h want 80000004", o_ifb_pc); end
    tick();
    tick();
    n_cmp++; if (n_acc !== 5) begin n_bad++; $display("FAIL bp_accepts2: got %0d want 5", n_acc); end
    n_cmp++; if (o_ifb_cnt !== 3'd4) begin n_bad++; $display("FAIL bp_cnt_refill: got %0d want 4", o_ifb_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    i_idu_ready = 1'b0; hold = 1'b1; i_mem_ack = 1'b1;
    tick();
    tick();
    i_mem_ack = 1'b0; i_exu_jmp_en = 1'b1; i_exu_jmp_pc = 32'h8000_0103;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_jmp: got %b want 0", o_ifb_mem_req); end
    tick();
    i_exu_jmp_en = 1'b0;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_flush: got %b want 0", o_ifb_mem_req); end
    hold = 1'b0; i_mem_ack = 1'b1;
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_drop2: got %b want 0", o_ifb_mem_req); end
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_drop1: got %b want 0", o_ifb_mem_req); end
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b1) begin n_bad++; $display("FAIL rd_req_run: got %b want 1", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rd_addr_tgt: got %h want 80000100", o_ifb_mem_addr); end
    n_cmp++; if (o_ifb_cnt !== 3'd0) begin n_bad++; $display("FAIL rd_cnt_dropped: got %0d want 0", o_ifb_cnt); end
    tick();
    n_cmp++; if (o_ifb_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_early: got %b want 0", o_ifb_valid); end
    tick();
    n_cmp++; if (o_ifb_valid !== 1'b1 || o_ifb_pc !== 32'h8000_0100) begin n_bad++; $display("FAIL rd_first_pc: got v=%b pc=%h want v=1 pc=80000100", o_ifb_valid, o_ifb_pc); end
    n_cmp++; if (o_ifb_inst !== 32'h7FFF_FEFF) begin n_bad++; $display("FAIL rd_first_inst: got %h want 7ffffeff", o_ifb_inst); end
  endtask

  task automatic test_jmp_in_flush();
    do_reset();
    i_idu_ready = 1'b0; hold = 1'b1; i_mem_ack = 1'b1;
    tick();
    tick();
    i_mem_ack = 1'b0; i_exu_jmp_en = 1'b1; i_exu_jmp_pc = 32'h0000_1000;
    tick();
    i_exu_jmp_pc = 32'h0000_2000;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL jf_req_jmp2: got %b want 0", o_ifb_mem_req); end
    tick();
    i_exu_jmp_en = 1'b0; hold = 1'b0; i_mem_ack = 1'b1;
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL jf_req_drop2: got %b want 0", o_ifb_mem_req); end
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL jf_req_drop1: got %b want 0", o_ifb_mem_req); end
    tick();
    n_cmp++; if (o_ifb_mem_req !== 1'b1) begin n_bad++; $display("FAIL jf_req_run: got %b want 1", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h0000_2000) begin n_bad++; $display("FAIL jf_addr_b: got %h want 00002000", o_ifb_mem_addr); end
  endtask

  task automatic test_ack_stall();
    do_reset();
    i_idu_ready = 1'b1; i_mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (o_ifb_mem_req !== 1'b1 || o_ifb_mem_addr !== 32'h8000_0000) begin
        n_bad++; $display("FAIL stall_hold%0d: got req=%b addr=%h want req=1 addr=80000000", i, o_ifb_mem_req, o_ifb_mem_addr);
      end
    end
    i_mem_ack = 1'b1;
    tick();
    n_cmp++; if (o_ifb_mem_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL stall_advance: got %h want 80000004", o_ifb_mem_addr); end
  endtask

  task automatic test_jmp_with_rvalid();
    do_reset();
    i_idu_ready = 1'b0; i_mem_ack = 1'b1; hold = 1'b1;
    tick();
    i_mem_ack = 1'b0; hold = 1'b0;
    tick();
    i_exu_jmp_en = 1'b1; i_exu_jmp_pc = 32'h0000_3000;
    #1;
    n_cmp++; if (i_mem_rvalid !== 1'b1 || o_ifb_mem_req !== 1'b0) begin n_bad++; $display("FAIL jr_setup: got rvalid=%b req=%b want rvalid=1 req=0", i_mem_rvalid, o_ifb_mem_req); end
    tick();
    i_exu_jmp_en = 1'b0; i_mem_ack = 1'b1;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b1) begin n_bad++; $display("FAIL jr_req_run: got %b want 1", o_ifb_mem_req); end
    n_cmp++; if (o_ifb_mem_addr !== 32'h0000_3000) begin n_bad++; $display("FAIL jr_addr: got %h want 00003000", o_ifb_mem_addr); end
    n_cmp++; if (o_ifb_cnt !== 3'd0 || o_ifb_valid !== 1'b0) begin n_bad++; $display("FAIL jr_discard: got cnt=%0d v=%b want cnt=0 v=0", o_ifb_cnt, o_ifb_valid); end
    tick();
    tick();
    n_cmp++; if (o_ifb_valid !== 1'b1 || o_ifb_pc !== 32'h0000_3000) begin n_bad++; $display("FAIL jr_first_pc: got v=%b pc=%h want v=1 pc=00003000", o_ifb_valid, o_ifb_pc); end
    n_cmp++; if (o_ifb_inst !== 32'hFFFF_CFFF) begin n_bad++; $display("FAIL jr_first_inst: got %h want ffffcfff", o_ifb_inst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_mem_ack = 1'b1; i_idu_ready = 1'b0;
    repeat (6) tick();
    n_cmp++; if (o_ifb_cnt !== 3'd4) begin n_bad++; $display("FAIL rm_cnt_before: got %0d want 4", o_ifb_cnt); end
    i_sys_rst = 1'b1;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b0 || o_ifb_valid !== 1'b0) begin n_bad++; $display("FAIL rm_outputs: got req=%b v=%b want 0 0", o_ifb_mem_req, o_ifb_valid); end
    n_cmp++; if (o_ifb_inst !== 32'h0 || o_ifb_pc !== 32'h0) begin n_bad++; $display("FAIL rm_head: got inst=%h pc=%h want 0 0", o_ifb_inst, o_ifb_pc); end
    tick();
    n_cmp++; if (o_ifb_cnt !== 3'd0) begin n_bad++; $display("FAIL rm_cnt_after: got %0d want 0", o_ifb_cnt); end
    i_sys_rst = 1'b0;
    #1;
    n_cmp++; if (o_ifb_mem_req !== 1'b1 || o_ifb_mem_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL rm_refetch: got req=%b addr=%h want 1 80000000", o_ifb_mem_req, o_ifb_mem_addr); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_acc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_jmp_in_flush();
    test_ack_stall();
    test_jmp_with_rvalid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
